// File: rtl/mac_pipe.sv
// mac_pipe: three-stage pipelined multi-lane multiply-accumulate with per-beat signed/unsigned and accumulate control
module mac_pipe #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int lanes   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [lanes*bw-1:0]   a,
   input  logic [lanes*bw-1:0]   b,
   input  logic [psum_bw-1:0]    c,
   input  logic                  signed_mode,
   input  logic                  acc_en,
   input  logic                  acc_clr,
   output logic [psum_bw-1:0]    out,
   output logic                  out_valid
);
   logic [lanes*bw-1:0] a_q, b_q;
   logic [psum_bw-1:0]  c1_q, c2_q, out_q, out_d, sum_d;
   logic                sm1_q, sm2_q, acc1_q, acc2_q;
   logic                v1_q, v2_q, vo_q;
   logic [2*bw-1:0]     p_d [lanes];
   logic [2*bw-1:0]     p_q [lanes];

   // Valid bits walk down the pipe; reset drops every in-flight beat, including one offered alongside reset
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         v1_q <= in_valid;
         v2_q <= v1_q;
      end
   end

   // Stage 1 captures a beat; acc_clr is folded into a single accumulate-select bit here
   always_ff @(posedge clk) begin
      if (in_valid) begin
         a_q    <= a;
         b_q    <= b;
         c1_q   <= c;
         sm1_q  <= signed_mode;
         acc1_q <= acc_en & ~acc_clr;
      end
   end

   // Lane products: operands are sign- or zero-extended to 2*bw so one multiplier serves both modes
   always_comb begin
      for (int i = 0; i < lanes; i++)
         p_d[i] = {{bw{sm1_q & a_q[i*bw+bw-1]}}, a_q[i*bw +: bw]} *
                  {{bw{sm1_q & b_q[i*bw+bw-1]}}, b_q[i*bw +: bw]};
   end

   // Stage 2 registers the products and forwards the partial sum and controls with them
   always_ff @(posedge clk) begin
      if (v1_q) begin
         p_q    <= p_d;
         c2_q   <= c1_q;
         sm2_q  <= sm2_d(sm1_q);
         acc2_q <= acc1_q;
      end
   end

   function automatic logic sm2_d(input logic s);
      return s;
   endfunction

   // Lane sum plus base; the lane sum always fits, only the base add may wrap
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < lanes; i++)
         sum_d = sum_d + {{(psum_bw-2*bw){sm2_q & p_q[i][2*bw-1]}}, p_q[i]};
      out_d = sum_d + (acc2_q ? out_q : c2_q);
   end

   // Stage 3: the output register doubles as the accumulator and holds across bubbles
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
         vo_q  <= 1'b0;
      end else begin
         vo_q <= v2_q;
         if (v2_q) out_q <= out_d;
      end
   end

   assign out       = out_q;
   assign out_valid = vo_q;
endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: randomized and directed self-checking bench for mac_pipe against a dot-product reference model
module tb_mac_pipe;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0, b = '0, c = '0;
   logic        sm = 1'b0, en = 1'b0, clr = 1'b0;
   logic [15:0] out;
   logic        out_valid;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        log_v [2048];
   logic [15:0] log_o [2048];
   bit          exp_v [2048];
   logic [15:0] exp_o [2048];
   logic [15:0] m_acc, m_hold;

   mac_pipe #(.bw(4), .psum_bw(16), .lanes(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .c(c),
      .signed_mode(sm), .acc_en(en), .acc_clr(clr), .out(out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      log_v[cyc] <= out_valid;
      log_o[cyc] <= out;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached at cycle %0d", cyc);
      $fatal(1);
   end

   function automatic int ref_dot(input logic [15:0] x, input logic [15:0] y, input logic s);
      int acc = 0;
      for (int i = 0; i < 4; i++) begin
         int xv, yv;
         xv = int'(x[i*4 +: 4]);
         yv = int'(y[i*4 +: 4]);
         if (s && xv > 7) xv -= 16;
         if (s && yv > 7) yv -= 16;
         acc += xv * yv;
      end
      return acc;
   endfunction

   task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] cv,
                        input logic s, input logic e, input logic r, output int k);
      a = av; b = bv; c = cv; sm = s; en = e; clr = r; in_valid = 1'b1;
      k = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset;
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); en = 1'b1; in_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0; in_valid = 1'b0;
      idle(4);
      for (int k = 1; k < cyc; k++) begin
         n_checks++; if (log_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc %0d got %b want 0", k, log_v[k]); end
         n_checks++; if (log_o[k] !== 16'd0) begin n_fail++; $display("FAIL reset_out cyc %0d got %h want 0000", k, log_o[k]); end
      end
   endtask

   task automatic test_dot;
      int k;
      drive(16'h4321, 16'h1111, 16'd10, 1'b0, 1'b0, 1'b0, k);
      idle(4);
      n_checks++; if (log_v[k+2] !== 1'b0) begin n_fail++; $display("FAIL dot_early got %b want 0", log_v[k+2]); end
      n_checks++; if (log_v[k+3] !== 1'b1) begin n_fail++; $display("FAIL dot_valid got %b want 1", log_v[k+3]); end
      n_checks++; if (log_o[k+3] !== 16'd20) begin n_fail++; $display("FAIL dot_out got %0d want 20", log_o[k+3]); end
      n_checks++; if (log_v[k+4] !== 1'b0) begin n_fail++; $display("FAIL dot_pulse got %b want 0", log_v[k+4]); end
   endtask

   task automatic test_signed;
      int k1, k2;
      drive(16'hFFFF, 16'h2222, 16'd0, 1'b1, 1'b0, 1'b0, k1);
      drive(16'hFFFF, 16'h2222, 16'd0, 1'b0, 1'b0, 1'b0, k2);
      idle(4);
      n_checks++; if (log_o[k1+3] !== 16'hFFF8) begin n_fail++; $display("FAIL signed_out got %h want fff8", log_o[k1+3]); end
      n_checks++; if (log_o[k2+3] !== 16'd120) begin n_fail++; $display("FAIL unsigned_out got %0d want 120", log_o[k2+3]); end
      n_checks++; if (log_v[k2+3] !== 1'b1) begin n_fail++; $display("FAIL unsigned_valid got %b want 1", log_v[k2+3]); end
   endtask

   task automatic test_acc_chain;
      int k, kd;
      logic [15:0] want;
      drive(16'h1111, 16'h1111, 16'd100, 1'b0, 1'b1, 1'b1, k);
      for (int i = 0; i < 3; i++) drive(16'h1111, 16'h1111, 16'($urandom), 1'b0, 1'b1, 1'b0, kd);
      idle(4);
      for (int i = 0; i < 4; i++) begin
         want = 16'(104 + 4*i);
         n_checks++; if (log_v[k+3+i] !== 1'b1) begin n_fail++; $display("FAIL acc_valid beat %0d got %b want 1", i, log_v[k+3+i]); end
         n_checks++; if (log_o[k+3+i] !== want) begin n_fail++; $display("FAIL acc_out beat %0d got %0d want %0d", i, log_o[k+3+i], want); end
      end
      n_checks++; if (log_v[k+7] !== 1'b0) begin n_fail++; $display("FAIL acc_tail got %b want 0", log_v[k+7]); end
   endtask

   task automatic test_wrap_bubbles;
      int k, k2;
      drive(16'h0001, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, k);
      idle(2);
      drive(16'h0000, 16'h0000, 16'd7, 1'b0, 1'b0, 1'b0, k2);
      idle(4);
      n_checks++; if (log_v[k+3] !== 1'b1 || log_o[k+3] !== 16'd0) begin n_fail++; $display("FAIL wrap_out got v=%b %h want v=1 0000", log_v[k+3], log_o[k+3]); end
      for (int i = 4; i < 6; i++) begin
         n_checks++; if (log_v[k+i] !== 1'b0 || log_o[k+i] !== 16'd0) begin n_fail++; $display("FAIL bubble_hold cyc +%0d got v=%b %h want v=0 0000", i, log_v[k+i], log_o[k+i]); end
      end
      n_checks++; if (log_v[k2+3] !== 1'b1 || log_o[k2+3] !== 16'd7) begin n_fail++; $display("FAIL after_bubble got v=%b %0d want v=1 7", log_v[k2+3], log_o[k2+3]); end
   endtask

   task automatic test_reset_midflight;
      int k1, k2, kn;
      drive(16'h1111, 16'h1111, 16'd50, 1'b0, 1'b0, 1'b0, k1);
      drive(16'h2222, 16'h1111, 16'd60, 1'b0, 1'b1, 1'b0, k2);
      a = 16'h3333; b = 16'h1111; c = 16'd70; in_valid = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      idle(5);
      for (int i = 1; i <= 8; i++) begin
         n_checks++; if (log_v[k1+i] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid cyc +%0d got %b want 0", i, log_v[k1+i]); end
         n_checks++; if (log_o[k1+i] !== (i < 3 ? 16'd7 : 16'd0)) begin n_fail++; $display("FAIL midrst_out cyc +%0d got %h want %h", i, log_o[k1+i], (i < 3 ? 16'd7 : 16'd0)); end
      end
      drive(16'h0001, 16'h0003, 16'd5, 1'b0, 1'b1, 1'b0, kn);
      idle(4);
      n_checks++; if (log_v[kn+2] !== 1'b0) begin n_fail++; $display("FAIL postrst_early got %b want 0", log_v[kn+2]); end
      n_checks++; if (log_v[kn+3] !== 1'b1 || log_o[kn+3] !== 16'd3) begin n_fail++; $display("FAIL postrst_acc got v=%b %0d want v=1 3", log_v[kn+3], log_o[kn+3]); end
   endtask

   task automatic test_max;
      int k;
      drive(16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 1'b0, 1'b0, k);
      idle(4);
      n_checks++; if (log_v[k+3] !== 1'b1 || log_o[k+3] !== 16'h0384) begin n_fail++; $display("FAIL max_out got v=%b %h want v=1 0384", log_v[k+3], log_o[k+3]); end
   endtask

   task automatic test_random;
      int s, k;
      logic [15:0] av, bv, cv, val;
      logic        ms, me, mr;
      int          base;
      s = cyc;
      m_acc = 16'd900;
      m_hold = 16'd900;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            av = 16'($urandom); bv = 16'($urandom); cv = 16'($urandom);
            ms = 1'($urandom); me = 1'($urandom); mr = ($urandom_range(0, 7) == 0);
            base = (me && !mr) ? int'(m_acc) : int'(cv);
            val = 16'(base + ref_dot(av, bv, ms));
            m_acc = val;
            exp_v[cyc+3] = 1'b1;
            exp_o[cyc+3] = val;
            drive(av, bv, cv, ms, me, mr, k);
         end else idle(1);
      end
      idle(4);
      for (int t = s + 1; t < cyc; t++) begin
         if (exp_v[t]) m_hold = exp_o[t];
         n_checks++; if (log_v[t] !== exp_v[t]) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b want %b", t, log_v[t], exp_v[t]); end
         n_checks++; if (log_o[t] !== m_hold) begin n_fail++; $display("FAIL rand_out cyc %0d got %h want %h", t, log_o[t], m_hold); end
      end
   endtask

   initial begin
      test_reset;
      test_dot;
      test_signed;
      test_acc_chain;
      test_wrap_bubbles;
      test_reset_midflight;
      test_max;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
